// File: rtl/regfile_sb_if.sv
// Bus bundle for regfile_sb: write port, issue port and two read ports.
// The master drives requests and addresses; the slave returns read data and busy flags.
interface regfile_sb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
);
   localparam int AW = $clog2(NREG);

   logic            WrEn;
   logic [2:0]      WrMode;
   logic [AW-1:0]   WriteAddress;
   logic [XLEN-1:0] WriteData;
   logic            IssueEn;
   logic [AW-1:0]   IssueAddress;
   logic [AW-1:0]   ReadAddress1;
   logic [AW-1:0]   ReadAddress2;
   logic [XLEN-1:0] ReadData1;
   logic [XLEN-1:0] ReadData2;
   logic            Busy1;
   logic            Busy2;

   modport master (
      output WrEn, WrMode, WriteAddress, WriteData,
      output IssueEn, IssueAddress, ReadAddress1, ReadAddress2,
      input  ReadData1, ReadData2, Busy1, Busy2
   );

   modport slave (
      input  WrEn, WrMode, WriteAddress, WriteData,
      input  IssueEn, IssueAddress, ReadAddress1, ReadAddress2,
      output ReadData1, ReadData2, Busy1, Busy2
   );
endinterface

// File: rtl/regfile_sb.sv
// Register file with a one-entry write stage (2-edge write latency) and per-register busy bits.
// Define REGFILE_BYPASS_EN to forward the pending write-stage data to the read ports.
module regfile_sb #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic         CLK,
   input  logic         rst,
   regfile_sb_if.slave  rf
);
   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] mem_q [NREG];
   logic [NREG-1:0] busy_q, busy_d;

   logic            wv_q, wv_d;
   logic [AW-1:0]   wa_q, wa_d;
   logic [XLEN-1:0] wd_q, wd_d;
   logic [XLEN-1:0] ext_data;

   always_comb begin
      ext_data = rf.WriteData;
      case (rf.WrMode)
         3'b001:  ext_data = {{(XLEN-8){rf.WriteData[7]}},   rf.WriteData[7:0]};
         3'b010:  ext_data = {{(XLEN-16){rf.WriteData[15]}}, rf.WriteData[15:0]};
         3'b011:  ext_data = {{(XLEN-8){1'b0}},              rf.WriteData[7:0]};
         3'b100:  ext_data = {{(XLEN-16){1'b0}},             rf.WriteData[15:0]};
         default: ext_data = rf.WriteData;
      endcase
   end

   // Writes to register 0 never enter the stage, so the array entry stays at its reset value.
   always_comb begin
      wv_d = rf.WrEn && (rf.WriteAddress != '0);
      wa_d = rf.WriteAddress;
      wd_d = ext_data;
   end

   // Clear from commit first, then set from issue so a same-edge issue wins.
   always_comb begin
      busy_d = busy_q;
      if (wv_q)
         busy_d[wa_q] = 1'b0;
      if (rf.IssueEn)
         busy_d[rf.IssueAddress] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         wv_q   <= 1'b0;
         wa_q   <= '0;
         wd_q   <= '0;
         busy_q <= '0;
         for (int i = 0; i < NREG; i++)
            mem_q[i] <= '0;
      end else begin
         wv_q   <= wv_d;
         wa_q   <= wa_d;
         wd_q   <= wd_d;
         busy_q <= busy_d;
         if (wv_q)
            mem_q[wa_q] <= wd_q;
      end
   end

   always_comb begin
      rf.ReadData1 = (rf.ReadAddress1 == '0) ? '0 : mem_q[rf.ReadAddress1];
      rf.ReadData2 = (rf.ReadAddress2 == '0) ? '0 : mem_q[rf.ReadAddress2];
`ifdef REGFILE_BYPASS_EN
      if (wv_q && (wa_q == rf.ReadAddress1) && (rf.ReadAddress1 != '0))
         rf.ReadData1 = wd_q;
      if (wv_q && (wa_q == rf.ReadAddress2) && (rf.ReadAddress2 != '0))
         rf.ReadData2 = wd_q;
`endif
      rf.Busy1 = busy_q[rf.ReadAddress1];
      rf.Busy2 = busy_q[rf.ReadAddress2];
   end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: register and data width in bits, minimum 16.
REQ-002 SHALL have parameter NREG, default 32: number of registers, a power of two from 2 to 64; AW = log2(NREG).
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port WrEn  input  1  write request this cycle.
REQ-006 SHALL have port WrMode  input  3  write extension mode: 000 word, 001 byte signed, 010 half signed, 011 byte unsigned, 100 half unsigned; 101-111 are treated as word.
REQ-007 SHALL have port WriteAddress  input  AW  destination register.
REQ-008 SHALL have port WriteData  input  XLEN  raw write data.
REQ-009 SHALL have port IssueEn  input  1  mark a register pending.
REQ-010 SHALL have port IssueAddress  input  AW  register to mark pending.
REQ-011 SHALL have ports ReadAddress1 and ReadAddress2  input  AW each  read addresses.
REQ-012 SHALL have ports ReadData1 and ReadData2  output  XLEN each  combinational read data.
REQ-013 SHALL have ports Busy1 and Busy2  output  1 each  pending flag of the addressed register.

Function
REQ-014 SHALL extend WriteData per WrMode at capture: byte uses bits [7:0] and half uses bits [15:0]; signed modes replicate the top bit of the field to XLEN, unsigned modes zero-fill to XLEN.
REQ-015 SHALL capture a write with WrEn=1 into a one-entry write stage (valid, address, extended data) at edge N and commit it to the array at edge N+1, giving a 2-edge write latency.
REQ-016 SHALL accept back-to-back writes every cycle: at each edge the stage commits its old entry and captures the new one.
REQ-017 SHALL keep register 0 at constant zero: writes to address 0 are discarded at capture, reads of 0 return 0, Busy of 0 is always 0.
REQ-018 SHALL drive ReadDataN as array[ReadAddressN], except where REQ-026 applies.
REQ-019 SHALL maintain one busy bit per register: IssueEn sets busy[IssueAddress] at the edge; a commit from the write stage clears busy[address] at the edge.
REQ-020 SHALL let set win over clear when issue and commit target the same register on the same edge.
REQ-021 SHALL drive BusyN as busy[ReadAddressN] combinationally, with no bypass of same-cycle issue.
REQ-022 SHALL give priority to the write-stage entry when WrEn captures the same address that the write stage is committing on the same edge, so the later data ends in the array one edge later.
REQ-023 SHALL allow a write to a register whose busy bit is clear: the data commits and the bit stays clear.

Reset
REQ-024 SHALL, while rst=1, clear all array entries to 0, all busy bits to 0 and the write-stage valid bit to 0, independent of CLK.
REQ-025 SHALL discard any uncommitted write-stage entry on reset mid-operation; after reset deasserts, ReadData1/2=0 and Busy1/2=0 for all addresses until new activity.

Configuration
REQ-026 SHALL, with macro REGFILE_BYPASS_EN defined, drive ReadDataN from the write-stage data when the stage is valid, the stage address equals ReadAddressN, and ReadAddressN is not 0.
REQ-027 SHALL, without REGFILE_BYPASS_EN, read only the array, so a read returns the old value until commit at edge N+1; all other behaviour is unchanged.

Verification
REQ-028 SHALL cover: reset asserted mid-run after writes -> every address reads 0 and Busy=0; write to 0 (WrEn, addr 0, data FFFF_FFFF) -> ReadData of 0 stays 0.
REQ-029 SHALL cover: WriteData=0000_00F0 written to reg 5 in modes 001, 011 and 010 -> reg 5 reads FFFF_FFF0, 0000_00F0 and 0000_00F0 respectively, each after 2 edges.
REQ-030 SHALL cover: write 1234_5678 to reg 3 at edge N while reading reg 3 -> with bypass, 1234_5678 between edges N and N+1; without bypass, the old value until N+1.
REQ-031 SHALL cover: IssueEn on reg 7, then a write to reg 7 -> Busy=1 from the issue edge until the commit edge, then 0; issue and commit on reg 7 in the same edge -> Busy stays 1.
REQ-032 SHALL cover: back-to-back writes to reg 9 of 1 then 2 -> reg 9 reads 2 finally, with no lost or reordered commits.
